// File: rtl/cordic_rotator.sv
// cordic_rotator: iterative rotation-mode CORDIC producing cos/sin of a
// signed Q16.16 angle, one micro-rotation per clock with start/done handshake.
// The arctangent table is external: lut_idx selects the entry and lut_angle
// returns it combinationally in the same cycle.
// Optional feature macro: CORDIC_QUAD_EXT_EN extends the input range to +/-pi
// by pre-rotating angles beyond +/-pi/2 by pi and negating the results.
module cordic_rotator #(
  parameter int          ITERATIONS = 16,
  parameter logic [31:0] K_INIT     = 32'd39797
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [31:0] angle_in,
  output logic        [31:0] lut_idx,
  input  logic signed [31:0] lut_angle,
  output logic               busy,
  output logic               done,
  output logic signed [31:0] cos_out,
  output logic signed [31:0] sin_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);

  state_t             state_q;
  logic signed [31:0] x_q, y_q, z_q;
  logic signed [31:0] x_d, y_d, z_d;
  logic        [4:0]  iter_q;
  logic               flip_q;
  logic               busy_q, done_q;
  logic signed [31:0] cos_q, sin_q;
  logic signed [31:0] z_load;
  logic               flip_load;
  logic signed [31:0] x_sh, y_sh;

  // Angle captured at start, folded into +/-pi/2 when the range extension is built in
  always_comb begin
    z_load    = angle_in;
    flip_load = 1'b0;
`ifdef CORDIC_QUAD_EXT_EN
    if (angle_in > 32'sd102944) begin
      z_load    = angle_in - 32'sd205887;
      flip_load = 1'b1;
    end else if (angle_in < -32'sd102944) begin
      z_load    = angle_in + 32'sd205887;
      flip_load = 1'b1;
    end
`endif
  end

  // One micro-rotation: direction follows the sign of the residual angle
  always_comb begin
    x_sh = x_q >>> iter_q;
    y_sh = y_q >>> iter_q;
    if (!z_q[31]) begin
      x_d = x_q - y_sh;
      y_d = y_q + x_sh;
      z_d = z_q - lut_angle;
    end else begin
      x_d = x_q + y_sh;
      y_d = y_q - x_sh;
      z_d = z_q + lut_angle;
    end
  end

  // Control FSM plus datapath registers; results are published in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      flip_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            x_q     <= K_INIT;
            y_q     <= '0;
            z_q     <= z_load;
            iter_q  <= '0;
            flip_q  <= flip_load;
          end
        end
        RUN: begin
          x_q    <= x_d;
          y_q    <= y_d;
          z_q    <= z_d;
          iter_q <= iter_q + 5'd1;
          if (iter_q == LAST_ITER) state_q <= DONE;
        end
        DONE: begin
          cos_q   <= flip_q ? -x_q : x_q;
          sin_q   <= flip_q ? -y_q : y_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Table index only meaningful while rotating; zero otherwise (and in reset)
  assign lut_idx = (state_q == RUN) ? 32'(iter_q) : 32'd0;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cos_out = cos_q;
  assign sin_out = sin_q;

endmodule

// File: tb/tb_cordic_rotator.sv
module tb_cordic_rotator;
  localparam int ITER = 16;
  localparam int TOL  = 8;
  localparam int RTOL = 12;
`ifdef CORDIC_QUAD_EXT_EN
  localparam int RANGE = 205887;
`else
  localparam int RANGE = 102944;
`endif

  logic               clk;
  logic               rst_n;
  logic               start;
  logic signed [31:0] angle_in;
  logic        [31:0] lut_idx;
  logic signed [31:0] lut_angle;
  logic               busy;
  logic               done;
  logic signed [31:0] cos_out;
  logic signed [31:0] sin_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int atan_tab [0:16];

  cordic_rotator #(.ITERATIONS(ITER), .K_INIT(32'd39797)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .angle_in(angle_in),
    .lut_idx(lut_idx), .lut_angle(lut_angle), .busy(busy), .done(done),
    .cos_out(cos_out), .sin_out(sin_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Arctangent table model: atan(2^-i) in Q16.16, combinational
  always_comb begin
    lut_angle = 32'sd0;
    if (lut_idx < 32'd17) lut_angle = atan_tab[lut_idx[4:0]];
  end

  function automatic int q16(input real r);
    return int'($floor(r * 65536.0 + 0.5));
  endfunction

  function automatic int ref_cos(input int a);
    return q16($cos(real'(a) / 65536.0));
  endfunction

  function automatic int ref_sin(input int a);
    return q16($sin(real'(a) / 65536.0));
  endfunction

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Drive one operation; report results, edges to done, busy cycles and index errors
  task automatic run_op(input int ang, output int c, output int s,
                        output int lat, output int busy_cnt, output int idx_err);
    angle_in = ang;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    lat = 0; busy_cnt = 0; idx_err = 0;
    while (!done && lat < 100) begin
      if (lat < ITER && lut_idx !== 32'(lat)) idx_err++;
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    c = cos_out;
    s = sin_out;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; angle_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_tests++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
    n_tests++; if (cos_out !== 32'sd0) begin n_fail++; $display("FAIL reset_cos got %0d want 0", cos_out); end
    n_tests++; if (sin_out !== 32'sd0) begin n_fail++; $display("FAIL reset_sin got %0d want 0", sin_out); end
    n_tests++; if (lut_idx !== 32'd0)  begin n_fail++; $display("FAIL reset_lut_idx got %0d want 0", lut_idx); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    int angs [$];
    int ec [$];
    int es [$];
    int c, s, lat, bc, ie;
    angs = '{0, 51471, -34315};
    ec   = '{65536, 46341, 56756};
    es   = '{0, 46341, -32768};
`ifdef CORDIC_QUAD_EXT_EN
    angs.push_back(154415);  ec.push_back(-46341); es.push_back(46341);
    angs.push_back(-205887); ec.push_back(-65536); es.push_back(0);
`endif
    for (int i = 0; i < angs.size(); i++) begin
      run_op(angs[i], c, s, lat, bc, ie);
      n_tests++; if (lat != ITER + 1) begin n_fail++; $display("FAIL dir_latency ang=%0d got %0d want %0d", angs[i], lat, ITER + 1); end
      n_tests++; if (ie != 0) begin n_fail++; $display("FAIL dir_lut_idx_seq ang=%0d got %0d bad indices want 0", angs[i], ie); end
      n_tests++; if (bc != ITER + 1) begin n_fail++; $display("FAIL dir_busy_cycles ang=%0d got %0d want %0d", angs[i], bc, ITER + 1); end
      n_tests++; if (absd(c, ec[i]) > TOL) begin n_fail++; $display("FAIL dir_cos ang=%0d got %0d want %0d", angs[i], c, ec[i]); end
      n_tests++; if (absd(s, es[i]) > TOL) begin n_fail++; $display("FAIL dir_sin ang=%0d got %0d want %0d", angs[i], s, es[i]); end
      @(posedge clk); #1;
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL dir_done_pulse ang=%0d got %0b want 0", angs[i], done); end
    end
  endtask

  task automatic test_random;
    int a, c, s, lat, bc, ie;
    for (int i = 0; i < 10; i++) begin
      a = int'($urandom_range(2 * RANGE, 0)) - RANGE;
      run_op(a, c, s, lat, bc, ie);
      n_tests++; if (lat != ITER + 1) begin n_fail++; $display("FAIL rnd_latency ang=%0d got %0d want %0d", a, lat, ITER + 1); end
      n_tests++; if (absd(c, ref_cos(a)) > RTOL) begin n_fail++; $display("FAIL rnd_cos ang=%0d got %0d want %0d", a, c, ref_cos(a)); end
      n_tests++; if (absd(s, ref_sin(a)) > RTOL) begin n_fail++; $display("FAIL rnd_sin ang=%0d got %0d want %0d", a, s, ref_sin(a)); end
    end
  endtask

  task automatic test_ignore_start;
    int ndone, c, s;
    c = 0; s = 0; ndone = 0;
    angle_in = 51471; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; angle_in = -34315;
    repeat (5) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 45; k++) begin
      if (done) begin
        if (ndone == 0) begin c = cos_out; s = sin_out; end
        ndone++;
      end
      @(posedge clk); #1;
    end
    n_tests++; if (ndone != 1) begin n_fail++; $display("FAIL ign_done_count got %0d want 1", ndone); end
    n_tests++; if (absd(c, 46341) > TOL) begin n_fail++; $display("FAIL ign_cos got %0d want 46341", c); end
    n_tests++; if (absd(s, 46341) > TOL) begin n_fail++; $display("FAIL ign_sin got %0d want 46341", s); end
  endtask

  task automatic test_reset_mid;
    int c, s, lat, bc, ie, w;
    angle_in = -34315; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (lut_idx !== 32'd8 && w < 30) begin @(posedge clk); #1; w++; end
    n_tests++; if (lut_idx !== 32'd8) begin n_fail++; $display("FAIL rstmid_reach_iter8 got %0d want 8", lut_idx); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rstmid_busy got %0b want 0", busy); end
    n_tests++; if (cos_out !== 32'sd0) begin n_fail++; $display("FAIL rstmid_cos got %0d want 0", cos_out); end
    n_tests++; if (sin_out !== 32'sd0) begin n_fail++; $display("FAIL rstmid_sin got %0d want 0", sin_out); end
    n_tests++; if (lut_idx !== 32'd0)  begin n_fail++; $display("FAIL rstmid_lut_idx got %0d want 0", lut_idx); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    w = 0;
    for (int k = 0; k < 20; k++) begin @(posedge clk); #1; if (done) w++; end
    n_tests++; if (w != 0) begin n_fail++; $display("FAIL rstmid_spurious_done got %0d want 0", w); end
    run_op(51471, c, s, lat, bc, ie);
    n_tests++; if (lat != ITER + 1) begin n_fail++; $display("FAIL rstmid_next_latency got %0d want %0d", lat, ITER + 1); end
    n_tests++; if (absd(c, 46341) > TOL) begin n_fail++; $display("FAIL rstmid_next_cos got %0d want 46341", c); end
    n_tests++; if (absd(s, 46341) > TOL) begin n_fail++; $display("FAIL rstmid_next_sin got %0d want 46341", s); end
  endtask

  task automatic test_back_to_back;
    int a [0:2];
    int tdone [0:2];
    int w;
    for (int i = 0; i < 3; i++) a[i] = int'($urandom_range(2 * RANGE, 0)) - RANGE;
    @(posedge clk); #1;
    angle_in = a[0]; start = 1'b1;
    @(posedge clk); #1;
    angle_in = a[1];
    for (int k = 0; k < 3; k++) begin
      w = 0;
      while (!done && w < 60) begin @(posedge clk); #1; w++; end
      tdone[k] = cyc;
      n_tests++; if (!done) begin n_fail++; $display("FAIL b2b_timeout op=%0d got no done want done", k); end
      n_tests++; if (absd(cos_out, ref_cos(a[k])) > RTOL) begin n_fail++; $display("FAIL b2b_cos op=%0d ang=%0d got %0d want %0d", k, a[k], cos_out, ref_cos(a[k])); end
      n_tests++; if (absd(sin_out, ref_sin(a[k])) > RTOL) begin n_fail++; $display("FAIL b2b_sin op=%0d ang=%0d got %0d want %0d", k, a[k], sin_out, ref_sin(a[k])); end
      if (k == 2) start = 1'b0;
      else begin
        @(posedge clk); #1;
        if (k == 0) angle_in = a[2];
      end
    end
    n_tests++; if (tdone[1] - tdone[0] != ITER + 2) begin n_fail++; $display("FAIL b2b_spacing01 got %0d want %0d", tdone[1] - tdone[0], ITER + 2); end
    n_tests++; if (tdone[2] - tdone[1] != ITER + 2) begin n_fail++; $display("FAIL b2b_spacing12 got %0d want %0d", tdone[2] - tdone[1], ITER + 2); end
    repeat (ITER + 4) begin @(posedge clk); #1; end
  endtask

  initial begin
    for (int i = 0; i < 17; i++) atan_tab[i] = q16($atan(2.0 ** (-i)));
    test_reset;
    test_directed;
    test_random;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
